// File: rtl/lf_osc_pkg.sv
// Shared types and default constants for the low-frequency oscillator model.
package lf_osc_pkg;

  // Oscillator power state.
  typedef enum logic [1:0] {
    OSC_OFF    = 2'd0,
    OSC_WARMUP = 2'd1,
    OSC_RUN    = 2'd2
  } osc_state_t;

  // 48 MHz system clock divided to 10 kHz.
  localparam int LF_HALF_PERIOD_DEF = 2400;
  // Warm-up time before the output may run.
  localparam int LF_STARTUP_DEF     = 100;

endpackage : lf_osc_pkg

// File: rtl/lf_clk_gate.sv
// Phase flop plus glitch-free enable gate for the divided clock.
// The gate only samples the enable while the output is (about to be) low,
// so a high pulse is never cut short and never starts mid-phase.
module lf_clk_gate (
  input  logic clk,
  input  logic rst_n,
  input  logic run_next,   // oscillator will be in RUN after this edge
  input  logic wrap,       // divider wraps on this edge
  input  logic clklfen,
  output logic clklf
);

  logic phase;
  logic gate;
  logic phase_next;
  logic gate_next;

  // Next phase/gate; both collapse to 0 whenever the oscillator leaves RUN.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    phase_next = 1'b0;
    gate_next  = 1'b0;
    if (run_next) begin
      phase_next = phase ^ wrap;
      gate_next  = phase_next ? gate : clklfen;
    end
  end

  // Phase, gate and the registered output clock.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      phase <= 1'b0;
      gate  <= 1'b0;
      clklf <= 1'b0;
    end else begin
      phase <= phase_next;
      gate  <= gate_next;
      clklf <= phase_next & gate_next;
    end
  end

endmodule : lf_clk_gate

// File: rtl/lf_osc_model.sv
// Portable model of the low-frequency oscillator primitive: power-up
// warm-up, ready flag, and a 50%-duty divided clock with glitch-free enable.
module lf_osc_model
  import lf_osc_pkg::*;
#(
  parameter int HALF_PERIOD    = LF_HALF_PERIOD_DEF,
  parameter int STARTUP_CYCLES = LF_STARTUP_DEF,
  parameter int CNT_W          = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clklfpu,
  input  logic clklfen,
  output logic clklf,
  output logic ready
);

  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(HALF_PERIOD - 1);

  osc_state_t       state;
  osc_state_t       state_next;
  logic [CNT_W-1:0] warm_cnt;
  logic [CNT_W-1:0] warm_cnt_next;
  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] div_cnt_next;
  logic             wrap;

  // Divider wrap; a power drop on the same edge overrides it via state_next.
  assign wrap = (state == OSC_RUN) && (div_cnt == DIV_LAST);

  // Next-state and counter logic; dropping power always returns to OFF.
  always_comb begin
    state_next    = state;
    warm_cnt_next = '0;
    div_cnt_next  = '0;
    if (!clklfpu) begin
      state_next = OSC_OFF;
    end else begin
      case (state)
        OSC_OFF: begin
          state_next = OSC_WARMUP;
        end
        OSC_WARMUP: begin
          if (warm_cnt == WARM_LAST) begin
            state_next = OSC_RUN;
          end else begin
            warm_cnt_next = warm_cnt + 1'b1;
          end
        end
        OSC_RUN: begin
          div_cnt_next = wrap ? '0 : div_cnt + 1'b1;
        end
        default: begin
          state_next = OSC_OFF;
        end
      endcase
    end
  end

  // State, counters and the registered ready flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= OSC_OFF;
      warm_cnt <= '0;
      div_cnt  <= '0;
      ready    <= 1'b0;
    end else begin
      state    <= state_next;
      warm_cnt <= warm_cnt_next;
      div_cnt  <= div_cnt_next;
      ready    <= (state_next == OSC_RUN);
    end
  end

  lf_clk_gate u_clk_gate (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_next (state_next == OSC_RUN),
    .wrap     (wrap),
    .clklfen  (clklfen),
    .clklf    (clklf)
  );

endmodule : lf_osc_model

// File: tb/tb_lf_osc_model.sv
// Self-checking bench for lf_osc_model with a cycle-level reference model
// built from elapsed-time arithmetic.
module tb_lf_osc_model;

  localparam int HP = 4;
  localparam int SC = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic clklfpu;
  logic clklfen;
  logic clklf;
  logic ready;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: 0=off, 1=warming, 2=running.
  int   m_mode   = 0;
  int   m_warm   = 0;   // warm-up cycles completed
  int   m_run_t  = 0;   // cycles since entering RUN
  logic m_gate   = 1'b0;
  logic exp_clklf = 1'b0;
  logic exp_ready = 1'b0;

  lf_osc_model #(
    .HALF_PERIOD    (HP),
    .STARTUP_CYCLES (SC),
    .CNT_W          (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clklfpu (clklfpu),
    .clklfen (clklfen),
    .clklf   (clklf),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    logic ph;
    if (!rst_n || !clklfpu) begin
      m_mode  = 0;
      m_warm  = 0;
      m_run_t = 0;
      m_gate  = 1'b0;
    end else if (m_mode == 0) begin
      m_mode = 1;
      m_warm = 0;
    end else if (m_mode == 1) begin
      m_warm++;
      if (m_warm == SC) begin
        m_mode  = 2;
        m_run_t = 0;
      end
    end else begin
      m_run_t++;
    end
    ph = 1'b0;
    if (m_mode == 2) begin
      ph = ((m_run_t / HP) % 2) == 1;
      if (!ph) m_gate = clklfen;
    end else begin
      m_gate = 1'b0;
    end
    exp_clklf = ph & m_gate;
    exp_ready = (m_mode == 2);
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, compare outputs.
  task automatic tick(input logic r, input logic pu, input logic en);
    rst_n   = r;
    clklfpu = pu;
    clklfen = en;
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    chk("clklf", clklf, exp_clklf);
    chk("ready", ready, exp_ready);
  endtask

  // Run with power and enable high until ready; check the edge count.
  task automatic warmup_count(input logic en, input int want);
    int n = 0;
    do begin
      tick(1'b1, 1'b1, en);
      n++;
    end while (!ready && n < 50);
    n_checks++;
    assert (n == want) else begin
      n_fail++;
      $error("FAIL warmup_len got=%0d exp=%0d", n, want);
    end
  endtask

  // Advance until clklf has just risen (bounded).
  task automatic wait_rise();
    int   n = 0;
    logic prev;
    do begin
      prev = clklf;
      tick(1'b1, 1'b1, 1'b1);
      n++;
    end while (!(clklf && !prev) && n < 40);
    n_checks++;
    assert (clklf === 1'b1) else begin
      n_fail++;
      $error("FAIL wait_rise got=%b exp=1 after %0d cycles", clklf, n);
    end
  endtask

  initial begin
    logic en_r;
    rst_n = 1'b0; clklfpu = 1'b1; clklfen = 1'b1;

    // 1: reset held with power and enable requested.
    repeat (3) begin
      tick(1'b0, 1'b1, 1'b1);
      chk("rst_clklf", clklf, 1'b0);
      chk("rst_ready", ready, 1'b0);
    end

    // 2: ready on edge 9, then 4 high / 4 low.
    warmup_count(1'b1, SC + 1);
    repeat (24) tick(1'b1, 1'b1, 1'b1);

    // 3: drop enable one cycle into a high phase, re-raise mid-low.
    wait_rise();
    repeat (10) tick(1'b1, 1'b1, 1'b0);
    repeat (16) tick(1'b1, 1'b1, 1'b1);

    // 4: one-cycle power drop in RUN restarts the full warm-up.
    wait_rise();
    tick(1'b1, 1'b0, 1'b1);
    chk("pd_clklf", clklf, 1'b0);
    chk("pd_ready", ready, 1'b0);
    warmup_count(1'b1, SC + 1);
    repeat (20) tick(1'b1, 1'b1, 1'b1);

    // 5: reset mid-high phase.
    wait_rise();
    tick(1'b0, 1'b1, 1'b1);
    chk("rh_clklf", clklf, 1'b0);
    chk("rh_ready", ready, 1'b0);
    warmup_count(1'b1, SC + 1);
    repeat (20) tick(1'b1, 1'b1, 1'b1);

    // 6: powered with enable low: ready, but no output clock.
    tick(1'b0, 1'b1, 1'b0);
    repeat (40) begin
      tick(1'b1, 1'b1, 1'b0);
      chk("en0_clklf", clklf, 1'b0);
    end
    chk("en0_ready", ready, 1'b1);

    // Randomized: enable toggles, occasional power drops and resets.
    en_r = 1'b1;
    repeat (800) begin
      if ($urandom_range(0, 7) == 0) en_r = ~en_r;
      tick(($urandom_range(0, 149) != 0),
           ($urandom_range(0, 39) != 0),
           en_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_lf_osc_model

// File: doc/lf_osc_model.md
Name: lf_osc_model

Overview:
Synthesizable, clock-domain-internal model of the low-frequency oscillator primitive (power-up, enable, low-speed clock out).
- Derives a slow 50%-duty clock from the system clock by counter division.
- Models power-up warm-up, glitch-free enable gating and a ready flag.
- Instantiated in top-level wrappers in place of the vendor primitive for simulation and portable builds.

Parameters:
HALF_PERIOD, 2400, system-clock cycles per clklf phase; full period is 2*HALF_PERIOD (48 MHz -> 10 kHz); legal range >=1.
STARTUP_CYCLES, 100, system-clock cycles spent in warm-up before the output may run; legal range >=1.
CNT_W, 16, width of internal counters; must hold max(HALF_PERIOD, STARTUP_CYCLES).

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst_n  input  1  synchronous active-low reset.
clklfpu  input  1  power-up request; 1 = oscillator powered.
clklfen  input  1  output enable; 1 = clklf toggles.
clklf  output  1  divided low-frequency clock, registered.
ready  output  1  1 while the oscillator is in RUN, registered.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge): state=OFF, clklf=0, ready=0, all counters=0, phase=0, gate=0. Reset has priority over all other inputs.
- States: OFF, WARMUP, RUN.
- OFF:
  - clklf=0, ready=0, counters held at 0.
  - clklfpu=1 sampled -> WARMUP next cycle with warm-up counter=0.
- WARMUP:
  - The warm-up counter increments each cycle.
  - After STARTUP_CYCLES cycles in WARMUP -> RUN. ready=1 from the first RUN cycle.
  - Divider counter=0, phase=0.
- RUN:
  - The divider counter counts 0..HALF_PERIOD-1 and wraps.
  - On the wrap cycle, phase toggles.
  - The divider free-runs regardless of clklfen.
- clklfpu=0 sampled in any state -> OFF next cycle. clklf=0, ready=0 and counters cleared in that same cycle. A mid-warm-up drop discards progress; re-power restarts the full warm-up.
- Enable gating, glitch-free:
  - The internal gate flop loads clklfen only on cycles where the next phase value is 0.
  - clklf = next_phase AND next_gate, registered.
  - A high pulse is never truncated.
  - The first high after enable begins only at a scheduled rising point.
- Timing with enable held high: clklf goes 1 exactly HALF_PERIOD cycles after entering RUN, then alternates HALF_PERIOD high / HALF_PERIOD low.
- clklfen changes during OFF or WARMUP have no visible effect until RUN.
- Simultaneous clklfpu=0 and the wrap event: the OFF transition wins.

Decomposition:
- Shared package lf_osc_pkg:
  - typedef enum osc_state_t {OSC_OFF, OSC_WARMUP, OSC_RUN}.
  - Default constants LF_HALF_PERIOD_DEF=2400, LF_STARTUP_DEF=100.
- One sub-module is natural: lf_clk_gate, the phase/gate flops implementing glitch-free enable. The FSM and counters stay in lf_osc_model.

Test Plan (HALF_PERIOD=4, STARTUP_CYCLES=8):
1. rst_n=0 for 3 cycles with clklfpu=1, clklfen=1 -> clklf=0, ready=0 throughout.
2. Release reset with clklfpu=1, clklfen=1:
   - WARMUP from the first edge; ready rises on edge 9.
   - clklf rises 4 cycles later, then exactly 4 high / 4 low repeatedly.
3. In RUN, drop clklfen 1 cycle into a high phase -> clklf stays high for the remaining 3 cycles, then stays 0. Raise clklfen mid-low -> the next rise occurs at the scheduled rising point, with a full 4-cycle high.
4. In RUN, drop clklfpu for 1 cycle:
   - Next cycle clklf=0, ready=0.
   - On re-raise, a full 8-cycle warm-up occurs before ready=1 and the pattern of scenario 2 repeats.
5. Assert rst_n=0 mid-high phase -> clklf=0, ready=0 on the next edge; after release, behaviour matches scenario 2.
6. clklfpu=1, clklfen=0 held for 40 cycles -> ready=1 after warm-up, clklf constant 0.
